// File: rtl/i2c_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_pkg                                                                  |
// | Shared types, frame geometry and line-drive helpers for the I2C master   |
// | write engine.                                                            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package i2c_pkg;

  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int SLOT_W  = $clog2(DATA_W);
  localparam int LCNT_W  = $clog2(FRAME_W + 1);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    LOAD  = 4'd1,
    START = 4'd2,
    ADDR  = 4'd3,
    ACK1  = 4'd4,
    DATA  = 4'd5,
    ACK2  = 4'd6,
    STOP  = 4'd7,
    DONE  = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    P3 = 2'd3
  } phase_e;

  // Bit presented on SDA for a given slot; ADDR slot ADDR_W is the W bit (0).
  function automatic logic tx_bit(input state_e st, input logic [SLOT_W-1:0] slot,
                                  input logic [FRAME_W-1:0] frame);
    logic [LCNT_W-1:0] idx;
    logic              b;
    idx = '0;
    b   = 1'b0;
    if (st == ADDR && slot != SLOT_W'(ADDR_W)) begin
      idx = LCNT_W'(FRAME_W - 1) - LCNT_W'(slot);
      b   = frame[idx];
    end else if (st == DATA) begin
      idx = LCNT_W'(DATA_W - 1) - LCNT_W'(slot);
      b   = frame[idx];
    end
    return b;
  endfunction

  // Returns {scl_oe, sda_oe} for a state/phase/bit combination.
  function automatic logic [1:0] line_drive(input state_e st, input phase_e ph, input logic b);
    logic scl;
    logic sda;
    scl = 1'b0;
    sda = 1'b0;
    case (st)
      START: begin
        sda = (ph != P0);
        scl = (ph == P2);
      end
      ADDR, DATA: begin
        scl = (ph == P0) || (ph == P3);
        sda = ~b;
      end
      ACK1, ACK2: begin
        scl = (ph == P0) || (ph == P3);
        sda = 1'b0;
      end
      STOP: begin
        scl = (ph == P0);
        sda = (ph != P2);
      end
      default: begin
        scl = 1'b0;
        sda = 1'b0;
      end
    endcase
    return {scl, sda};
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_tick_gen                                                             |
// | Quarter-SCL-period strobe: one tick every CLK_DIV enabled, unheld cycles.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module i2c_tick_gen #(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  input  logic hold_i,
  output logic tick_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || clr_i) begin
      cnt_d = '0;
    end else if (hold_i) begin
      cnt_d = cnt_q;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && !clr_i && !hold_i && (cnt_q == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/i2c_master_wr_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_master_wr_engine                                                     |
// | Loads a 15-bit {addr,data} frame serially and performs one open-drain    |
// | I2C single-byte write. Optional: I2C_CLK_STRETCH_EN (slave stretching).  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module i2c_master_wr_engine
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_bit,
  input  logic frame_bit_vld,
  output logic busy,
  output logic done,
  output logic nack,
  output logic scl_oe,
  output logic sda_oe,
  input  logic sda_in,
  input  logic scl_in
);

  state_e              state_q, state_d;
  phase_e              phase_q, phase_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
  logic [FRAME_W-1:0]  shreg_q, shreg_d;
  logic                nack_q, nack_d;
  logic                ack_q, ack_d;
  logic                scl_oe_q, sda_oe_q;
  logic [1:0]          drv_d;

  logic w_tick;
  logic w_tick_en;
  logic w_tick_clr;
  logic w_tick_hold;

  assign w_tick_en  = !(state_q inside {IDLE, LOAD});
  assign w_tick_clr = (state_q != START) && (state_d == START);

`ifdef I2C_CLK_STRETCH_EN
  // Freeze phase timing while SCL is released but a slave holds it low.
  assign w_tick_hold = !scl_oe_q && !scl_in && (phase_q == P1) &&
                       (state_q inside {ADDR, ACK1, DATA, ACK2, STOP});
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign w_tick_hold   = 1'b0;
`endif

  i2c_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .en_i   (w_tick_en),
    .clr_i  (w_tick_clr),
    .hold_i (w_tick_hold),
    .tick_o (w_tick)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    slot_d  = slot_q;
    lcnt_d  = lcnt_q;
    shreg_d = shreg_q;
    nack_d  = nack_q;
    ack_d   = ack_q;

    case (state_q)
      IDLE, LOAD: begin
        if (frame_bit_vld) begin
          shreg_d = {shreg_q[FRAME_W-2:0], frame_bit};
          lcnt_d  = lcnt_q + 1'b1;
          state_d = LOAD;
          if (state_q == IDLE) begin
            nack_d = 1'b0;
          end
          if (lcnt_q == LCNT_W'(FRAME_W - 1)) begin
            state_d = START;
            phase_d = P0;
            lcnt_d  = '0;
          end
        end
      end

      START: begin
        if (w_tick) begin
          if (phase_q == P2) begin
            state_d = ADDR;
            phase_d = P0;
            slot_d  = '0;
          end else begin
            phase_d = phase_e'(phase_q + 2'd1);
          end
        end
      end

      ADDR, DATA: begin
        if (w_tick) begin
          phase_d = phase_e'(phase_q + 2'd1);
          if (phase_q == P3) begin
            slot_d = slot_q + 1'b1;
            if (slot_q == SLOT_W'(DATA_W - 1)) begin
              state_d = (state_q == ADDR) ? ACK1 : ACK2;
            end
          end
        end
      end

      ACK1, ACK2: begin
        if (w_tick) begin
          phase_d = phase_e'(phase_q + 2'd1);
          if (phase_q == P1) begin
            ack_d = sda_in;
          end
          if (phase_q == P3) begin
            if (ack_q) begin
              nack_d = 1'b1;
            end
            // An address NACK skips the data byte entirely.
            state_d = (state_q == ACK1 && !ack_q) ? DATA : STOP;
          end
        end
      end

      STOP: begin
        if (w_tick) begin
          if (phase_q == P2) begin
            state_d = DONE;
            phase_d = P0;
          end else begin
            phase_d = phase_e'(phase_q + 2'd1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Line drives are registered from next-state so the pads never glitch.
    drv_d = line_drive(state_d, phase_d, tx_bit(state_d, slot_d, shreg_d));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      phase_q  <= P0;
      slot_q   <= '0;
      lcnt_q   <= '0;
      shreg_q  <= '0;
      nack_q   <= 1'b0;
      ack_q    <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      slot_q   <= slot_d;
      lcnt_q   <= lcnt_d;
      shreg_q  <= shreg_d;
      nack_q   <= nack_d;
      ack_q    <= ack_d;
      scl_oe_q <= drv_d[1];
      sda_oe_q <= drv_d[0];
    end
  end

  assign busy   = !(state_q inside {IDLE, DONE});
  assign done   = (state_q == DONE);
  assign nack   = nack_q;
  assign scl_oe = scl_oe_q;
  assign sda_oe = sda_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_wr_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_i2c_master_wr_engine                                                  |
// | Directed + randomized bench with an I2C slave/bus model.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_i2c_master_wr_engine;

  localparam int D      = 4;
  localparam int BUDGET = 2000;

  logic clk = 1'b0;
  logic rst;
  logic frame_bit;
  logic frame_bit_vld;
  logic sda_in;
  logic scl_in;
  logic busy;
  logic done;
  logic nack;
  logic scl_oe;
  logic sda_oe;

  logic slv_pull = 1'b0;
  logic stretch  = 1'b0;
  logic plan_na  = 1'b0;
  logic plan_nd  = 1'b0;

  int tests = 0;
  int fails = 0;

  logic got_q[$];
  int   n_rise    = 0;
  int   chg_hi    = 0;
  logic prev_scl  = 1'b0;
  logic prev_sda  = 1'b0;
  logic prev_busy = 1'b0;

  always #5 clk = ~clk;

  // Open-drain bus: lines are high unless someone pulls them low.
  assign sda_in = ~(sda_oe | slv_pull);
  assign scl_in = ~(scl_oe | stretch);

  i2c_master_wr_engine #(
    .CLK_DIV (D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_bit     (frame_bit),
    .frame_bit_vld (frame_bit_vld),
    .busy          (busy),
    .done          (done),
    .nack          (nack),
    .scl_oe        (scl_oe),
    .sda_oe        (sda_oe),
    .sda_in        (sda_in),
    .scl_in        (scl_in)
  );

  // Slave model: records SDA at each SCL rise, drives ACK per plan.
  always @(negedge clk) begin
    if (busy && !prev_busy) begin
      got_q.delete();
      n_rise   = 0;
      chg_hi   = 0;
      slv_pull = 1'b0;
    end
    if (prev_scl && !scl_oe) begin
      n_rise++;
      got_q.push_back(sda_in);
    end
    if (!prev_scl && scl_oe) begin
      if (n_rise == 8)       slv_pull = ~plan_na;
      else if (n_rise == 17) slv_pull = ~plan_nd;
      else                   slv_pull = 1'b0;
    end
    if (!prev_scl && !scl_oe && (sda_oe != prev_sda)) chg_hi++;
    if (rst) slv_pull = 1'b0;
    prev_scl  = scl_oe;
    prev_sda  = sda_oe;
    prev_busy = busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [14:0] f, input bit gaps, input string tag);
    for (int i = 14; i >= 0; i--) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      if (gaps && i == 0) begin
        repeat (10) begin
          @(posedge clk); #1;
        end
        check({tag, "_no_early_start"}, {busy, scl_oe, sda_oe}, 3'b100);
      end
      frame_bit_vld = 1'b1;
      frame_bit     = f[i];
      @(posedge clk); #1;
      frame_bit_vld = 1'b0;
      frame_bit     = 1'b0;
      if (i == 14) check({tag, "_first_bit"}, {busy, nack}, 2'b10);
    end
  endtask

  task automatic run_txn(input logic [14:0] f, input bit na, input bit nd, input bit gaps,
                         input bit junk, input int stall, input string tag);
    int   cyc;
    int   exp_cyc;
    logic exp_q[$];
    plan_na = na;
    plan_nd = nd & ~na;
    send_frame(f, gaps, tag);
    cyc = 0;
    while (cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (done) break;
      if (stall > 0 && cyc == 16 * D + 1)         stretch = 1'b1;
      if (stall > 0 && cyc == 16 * D + 1 + stall) stretch = 1'b0;
      if (junk) begin
        frame_bit_vld = 1'($urandom_range(0, 1));
        frame_bit     = 1'($urandom_range(0, 1));
      end
    end
    frame_bit_vld = 1'b0;
    frame_bit     = 1'b0;
    stretch       = 1'b0;

    // START(3) + addr/W + ACK (9 slots) [+ data + ACK (9 slots)] + STOP(3), plus DONE cycle.
    exp_cyc = (na ? (3 + 36 + 3) : (3 + 72 + 3)) * D + 1 + stall;
    check({tag, "_latency"}, cyc, exp_cyc);
    check({tag, "_done_busy"}, {done, busy}, 2'b10);
    check({tag, "_nack"}, nack, (na | nd));

    for (int i = 14; i >= 8; i--) exp_q.push_back(f[i]);
    exp_q.push_back(1'b0);
    exp_q.push_back(na);
    if (!na) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back(f[i]);
      exp_q.push_back(nd);
    end
    exp_q.push_back(1'b0);

    check({tag, "_nbits"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_bit%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_sda_chg_scl_high"}, chg_hi, 2);

    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {done, busy}, 2'b00);
  endtask

  initial begin
    logic [14:0] f;
    bit          na;
    bit          nd;

    rst           = 1'b1;
    frame_bit     = 1'b0;
    frame_bit_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_outs", {busy, done, nack, scl_oe, sda_oe}, 5'b0);

    run_txn(15'h50A5, 1'b0, 1'b0, 1'b0, 1'b0, 0, "ack_wr");

    f = 15'($urandom);
    run_txn(f, 1'b1, 1'b0, 1'b0, 1'b0, 0, "addr_nack");
    repeat (5) @(posedge clk);
    #1;
    check("nack_sticky", {nack, busy}, 2'b10);

    // Partial load then reset: engine must forget it and nack must clear.
    f = 15'($urandom);
    for (int i = 14; i >= 8; i--) begin
      frame_bit_vld = 1'b1;
      frame_bit     = f[i];
      @(posedge clk); #1;
    end
    frame_bit_vld = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_midload", {busy, done, nack, scl_oe, sda_oe}, 5'b0);

    f = 15'($urandom);
    run_txn(f, 1'b0, 1'b0, 1'b0, 1'b0, 0, "fresh");

    f = 15'($urandom);
    run_txn(f, 1'b0, 1'b1, 1'b0, 1'b0, 0, "data_nack");

    f = 15'($urandom);
    run_txn(f, 1'b0, 1'b0, 1'b1, 1'b1, 0, "gap_junk");

    // Reset in the middle of the address phase releases both lines at once.
    plan_na = 1'b0;
    plan_nd = 1'b0;
    f = 15'($urandom);
    send_frame(f, 1'b0, "rst_txn");
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_midtxn", {busy, done, scl_oe, sda_oe}, 4'b0);

    for (int k = 0; k < 4; k++) begin
      f  = 15'($urandom);
      na = 1'($urandom_range(0, 1));
      nd = 1'($urandom_range(0, 1));
      run_txn(f, na, nd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
              $sformatf("rand%0d", k));
    end

`ifdef I2C_CLK_STRETCH_EN
    f = 15'($urandom);
    run_txn(f, 1'b0, 1'b0, 1'b0, 1'b0, 20, "stretch");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_master_wr_engine.md
Name: i2c_master_wr_engine

Overview:
- Downstream consumer of the I2C serial FIFO.
- Collects one 15-bit frame, serially and MSB first: 7-bit slave address, then 8-bit data byte.
- Executes one I2C single-byte write on open-drain SCL/SDA: START, addr+W, ACK, data, ACK, STOP.
- Reports completion and NACK status to the controlling logic.

Parameters:
- CLK_DIV, 250: clk cycles per quarter SCL period. SCL period = 4*CLK_DIV. Legal range 2..65535.
- FRAME_W, 15: frame width. Fixed at ADDR_W+DATA_W.
- ADDR_W, 7: slave address width.
- DATA_W, 8: payload width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_bit  in  1  serial frame bit from FIFO data_out
- frame_bit_vld  in  1  frame_bit valid this cycle
- busy  out  1  high from first accepted bit until STOP completes
- done  out  1  one-cycle pulse after STOP
- nack  out  1  sticky; slave NACKed last transaction
- scl_oe  out  1  1 = pull SCL low; 0 = release
- sda_oe  out  1  1 = pull SDA low; 0 = release
- sda_in  in  1  sampled SDA line (pre-synchronised)
- scl_in  in  1  sampled SCL line; used only with I2C_CLK_STRETCH_EN

Behaviour:
- Reset: scl_oe=0, sda_oe=0, busy=0, done=0, nack=0, state=IDLE, bit/phase/tick counters=0, shift reg=0.
- Frame load:
  - In IDLE or LOAD, each cycle with frame_bit_vld=1 shifts frame_bit into a 15-bit register, MSB first, and increments the load count.
  - The first accepted bit moves IDLE->LOAD, sets busy=1 and clears nack.
  - On the 15th bit, go to START on the next cycle.
  - Gaps (vld=0) mid-load are allowed.
  - frame_bit_vld is ignored in START..STOP.
- Tick generator: quarter-period strobe every CLK_DIV cycles while state is not IDLE or LOAD; restarts at 0 on entry to START.
- Each bit slot is 4 quarter phases (p0..p3):
  - p0: scl_oe=1, SDA updated.
  - p1, p2: scl_oe=0.
  - p3: scl_oe=1.
  - ACK is sampled from sda_in at the end of p1.
- States, each advancing on the tick:
  - START, 3 phases: (SDA rel, SCL rel) -> (sda_oe=1) -> (scl_oe=1).
  - ADDR, 8 slots: addr[6] first, then W bit = 0. sda_oe = ~bit.
  - ACK1, 1 slot: sda_oe=0. sda_in=1 -> nack=1 and go to STOP (data skipped). Otherwise go to DATA.
  - DATA, 8 slots: data[7] first.
  - ACK2, 1 slot: sda_in=1 -> nack=1. Always go to STOP.
  - STOP, 3 phases: (scl_oe=1, sda_oe=1) -> (scl_oe=0) -> (sda_oe=0).
  - DONE: done=1 for 1 cycle, busy=0, then IDLE.
- Latency: a full ACKed transaction from START entry to done takes (3+9*4+9*4+3)*CLK_DIV + 1 cycles.
- SDA is changed only while SCL is low, except for the START and STOP edges.
- rst mid-transaction: immediate return to the reset values on the next edge. Both lines are released; no STOP is generated.
- Frame arriving while busy: bits dropped. Upstream must gate on busy.

Optional Feature:
- I2C_CLK_STRETCH_EN defined:
  - In p1 of every slot and in the STOP release phase, the tick counter holds while scl_oe=0 and scl_in=0 (slave stretching).
  - Phase timing resumes the cycle after scl_in=1.
- Undefined: scl_in is ignored; timing is purely tick-driven.

Decomposition:
- i2c_pkg holds:
  - state enum: IDLE, LOAD, START, ADDR, ACK1, DATA, ACK2, STOP, DONE
  - constants FRAME_W, ADDR_W, DATA_W
  - phase encoding P0..P3
- Sub-module i2c_tick_gen: CLK_DIV counter with enable, clear and hold inputs, and a tick output.

Test Plan:
- Reset: hold rst 3 cycles mid-load -> all outputs 0, state IDLE; the next 15 bits load a fresh frame.
- ACKed write: CLK_DIV=4, frame 0x50A5 (addr 0x50, data 0xA5), sda_in=0 during both ACKs -> SDA shows 1010000,0 then 10100101; done pulses at cycle 4*(3+72+3)+1 after START; nack=0.
- Address NACK: sda_in=1 in ACK1 -> no DATA slots; STOP follows immediately; nack=1 held until the next frame's first bit.
- Data NACK: sda_in=0 in ACK1, 1 in ACK2 -> all 8 data bits sent, then STOP; nack=1.
- Gapped load and busy drop: 15 bits with vld toggling -> START only after the 15th; extra vld pulses while busy do not alter the transmitted bits.
- Stretch (I2C_CLK_STRETCH_EN): hold scl_in=0 for 20 cycles in p1 of addr bit 3 -> that SCL high phase is extended by 20 cycles; total transaction is 20 cycles longer.
